// File: rtl/ccu_snoop_dispatch.sv
// Per-port snoop dispatcher between the CCU and the core snoop interfaces.
// Tracks one outstanding snoop per port and flags AC/CR/CD protocol violations.

package ccu_snoop_dispatch_pkg;

    localparam int unsigned AXI_ADDR_WIDTH    = 64;
    localparam int unsigned DCACHE_LINE_WIDTH = 512;
    localparam int unsigned CD_DATA_WIDTH     = 256;
    localparam int unsigned CR_RESP_WIDTH     = 5;

    typedef struct packed {
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [3:0]                snoop;
        logic [2:0]                prot;
    } ac_chan_t;

    typedef struct packed {
        logic [CD_DATA_WIDTH-1:0] data;
        logic                     last;
    } cd_chan_t;

    typedef struct packed {
        logic     ac_valid;
        ac_chan_t ac;
        logic     cr_ready;
        logic     cd_ready;
    } snoop_req_t;

    typedef struct packed {
        logic                     ac_ready;
        logic                     cr_valid;
        logic [CR_RESP_WIDTH-1:0] cr_resp;
        logic                     cd_valid;
        cd_chan_t                 cd;
    } snoop_resp_t;

endpackage

module ccu_snoop_dispatch #(
    parameter int unsigned NoPorts      = 0,
    parameter int unsigned AxiAddrWidth = 64,
    parameter int unsigned CdBeats      = 2,
    parameter type         snoop_req_t  = ccu_snoop_dispatch_pkg::snoop_req_t,
    parameter type         snoop_resp_t = ccu_snoop_dispatch_pkg::snoop_resp_t
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  snoop_req_t  [NoPorts-1:0]              ccu_snoop_req_i,
    output snoop_resp_t [NoPorts-1:0]              ccu_snoop_resp_o,
    output snoop_req_t  [NoPorts-1:0]              core_snoop_req_o,
    input  snoop_resp_t [NoPorts-1:0]              core_snoop_resp_i,
    output logic        [NoPorts-1:0]              snoop_busy_o,
    output logic        [NoPorts-1:0][AxiAddrWidth-1:0] snoop_line_o,
    output logic        [NoPorts-1:0]              snoop_err_o
);

    localparam int unsigned LineOffBits = $clog2(ccu_snoop_dispatch_pkg::DCACHE_LINE_WIDTH / 8);
    localparam int unsigned CntW        = $clog2(CdBeats + 1);

    typedef logic [CntW-1:0] cnt_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_CR = 2'd1,
        WAIT_CD = 2'd2
    } snoop_state_e;

    if (NoPorts == 0) begin : g_none
        // Degenerate configuration: nothing to dispatch.
        logic unused_in;
        assign unused_in        = ^{clk_i, rst_i, ccu_snoop_req_i, core_snoop_resp_i};
        assign ccu_snoop_resp_o = '0;
        assign core_snoop_req_o = '0;
        assign snoop_busy_o     = '0;
        assign snoop_line_o     = '0;
        assign snoop_err_o      = '0;
    end else begin : g_ports
        for (genvar p = 0; p < NoPorts; p++) begin : g_port
            snoop_state_e            state_q, state_d;
            cnt_t                    cnt_q, cnt_d;
            logic                    done_q, done_d;
            logic                    err_q, err_d;
            logic [AxiAddrWidth-1:0] line_q, line_d;

            snoop_req_t  ccu_req, core_req;
            snoop_resp_t core_rsp, ccu_rsp;
            logic        ac_hs, cr_hs, cd_hs, cd_last_hs;

            assign ccu_req    = ccu_snoop_req_i[p];
            assign core_rsp   = core_snoop_resp_i[p];
            assign ac_hs      = (state_q == IDLE) && ccu_req.ac_valid && core_rsp.ac_ready;
            assign cr_hs      = core_rsp.cr_valid && ccu_req.cr_ready;
            assign cd_hs      = core_rsp.cd_valid && ccu_req.cd_ready;
            assign cd_last_hs = cd_hs && core_rsp.cd.last;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    line_q  <= '0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    done_q  <= done_d;
                    err_q   <= err_d;
                    line_q  <= line_d;
                end
            end

            always_comb begin
                core_req = ccu_req;
                ccu_rsp  = core_rsp;
                state_d  = state_q;
                cnt_d    = cnt_q;
                done_d   = done_q;
                err_d    = err_q;
                line_d   = line_q;

                // Only one snoop in flight: block new AC until back in IDLE.
                if (state_q != IDLE) begin
                    core_req.ac_valid = 1'b0;
                    ccu_rsp.ac_ready  = 1'b0;
                end

                case (state_q)
                    IDLE: begin
                        if (cr_hs || cd_hs) begin
                            err_d = 1'b1;
                        end
                        if (ac_hs) begin
                            state_d = WAIT_CR;
                            line_d  = {ccu_req.ac.addr[AxiAddrWidth-1:LineOffBits],
                                       LineOffBits'(0)};
                            cnt_d   = '0;
                            done_d  = 1'b0;
                        end
                    end
                    WAIT_CR, WAIT_CD: begin
                        if (cd_hs) begin
                            if (cnt_q != cnt_t'(CdBeats)) begin
                                cnt_d = cnt_q + cnt_t'(1);
                            end
                            if (core_rsp.cd.last) begin
                                done_d = 1'b1;
                                if (cnt_q != cnt_t'(CdBeats - 1)) begin
                                    err_d = 1'b1;
                                end
                            end else if (cnt_q >= cnt_t'(CdBeats - 1)) begin
                                err_d = 1'b1;
                            end
                        end
                        if (state_q == WAIT_CR) begin
                            if (cr_hs) begin
                                if (!core_rsp.cr_resp[0]) begin
                                    state_d = IDLE;
                                    if ((cnt_q != '0) || cd_hs) begin
                                        err_d = 1'b1;
                                    end
                                end else if (done_q || cd_last_hs) begin
                                    state_d = IDLE;
                                end else begin
                                    state_d = WAIT_CD;
                                end
                            end
                        end else if (cd_last_hs) begin
                            state_d = IDLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end

            assign core_snoop_req_o[p] = core_req;
            assign ccu_snoop_resp_o[p] = ccu_rsp;
            assign snoop_busy_o[p]     = (state_q != IDLE);
            assign snoop_line_o[p]     = line_q;
            assign snoop_err_o[p]      = err_q;
        end
    end

endmodule

// File: doc/ccu_snoop_dispatch.md
CCU_SNOOP_DISPATCH -- requirements
Module: ccu_snoop_dispatch

Interface
REQ-001 SHALL have parameter NoPorts, default 0: number of core snoop ports.
REQ-002 SHALL have parameter AxiAddrWidth, default 64: snoop address width.
REQ-003 SHALL have parameter CdBeats, default 2: CD beats per cache line (DCACHE_LINE_WIDTH / CD data width), >=1.
REQ-004 SHALL have parameters snoop_req_t, default logic (ac_valid, ac.addr/snoop/prot, cr_ready, cd_ready) and snoop_resp_t, default logic (ac_ready, cr_valid, cr_resp, cd_valid, cd.data/last).
REQ-005 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port ccu_snoop_req_i  input  [NoPorts] snoop_req_t  snoop requests from CCU.
REQ-008 SHALL have port ccu_snoop_resp_o  output  [NoPorts] snoop_resp_t  snoop responses to CCU.
REQ-009 SHALL have port core_snoop_req_o  output  [NoPorts] snoop_req_t  snoop requests to cores.
REQ-010 SHALL have port core_snoop_resp_i  input  [NoPorts] snoop_resp_t  snoop responses from cores.
REQ-011 SHALL have port snoop_busy_o  output  [NoPorts]  port has an outstanding snoop.
REQ-012 SHALL have port snoop_line_o  output  [NoPorts][AxiAddrWidth]  line address of outstanding snoop, for request-path collision checks.
REQ-013 SHALL have port snoop_err_o  output  [NoPorts]  sticky protocol error.

Function
REQ-014 SHALL keep per port an FSM IDLE, WAIT_CR, WAIT_CD; one outstanding snoop per port max.
REQ-015 All fields SHALL pass through combinationally (req CCU->core, resp core->CCU) except where gated below.
REQ-016 IDLE: ac_valid/ac_ready pass; on AC handshake latch line = ac.addr with low $clog2(DCACHE_LINE_WIDTH/8) bits zeroed, clear beat counter and cd_done, go WAIT_CR.
REQ-017 WAIT_CR/WAIT_CD: core ac_valid and CCU ac_ready SHALL be forced 0.
REQ-018 CD handshakes (cd_valid & cd_ready) SHALL be counted in WAIT_CR and WAIT_CD; counter saturates at CdBeats; cd.last handshake sets cd_done.
REQ-019 WAIT_CR on CR handshake: cr_resp[0] (DataTransfer)=1 and cd_done=0 -> WAIT_CD; DataTransfer=1 and cd_done (or last this cycle) -> IDLE; DataTransfer=0 -> IDLE.
REQ-020 WAIT_CD: on cd.last handshake -> IDLE.
REQ-021 Error (sets snoop_err_o[p], sticky): cd.last at count != CdBeats-1; count reaches CdBeats without last; CR with DataTransfer=0 after CD beats seen; CR or CD handshake in IDLE.
REQ-022 snoop_busy_o[p] SHALL be 1 iff state != IDLE, asserted the cycle after AC handshake, deasserted the cycle after completion.
REQ-023 snoop_line_o[p] SHALL hold the latched line while busy and the last latched value when idle.
REQ-024 Completion and new AC SHALL NOT overlap: AC for the next snoop is accepted no earlier than the cycle after returning to IDLE.
REQ-025 Ports SHALL be fully independent; no cross-port arbitration.

Reset
REQ-026 rst_i=1 at a clock edge SHALL set all FSMs IDLE, counters 0, cd_done 0, snoop_line_o 0, snoop_err_o 0, snoop_busy_o 0, including mid-transaction; gating takes IDLE values the next cycle.

Verification
REQ-027 AC addr 0x1234 port 0, CR resp 0 -> busy 1 for AC-to-CR cycles, line 0x1200 (64 B line), back IDLE, err 0.
REQ-028 AC then CR DataTransfer=1, then 2 CD beats with last on beat 2 (CdBeats=2) -> WAIT_CD then IDLE after last, err 0.
REQ-029 CD 2 beats before CR, then CR DataTransfer=1 -> IDLE directly on CR cycle, err 0.
REQ-030 Second AC on port 0 while WAIT_CR -> core ac_valid 0, CCU ac_ready 0 until cycle after completion; port 1 AC accepted meanwhile.
REQ-031 CD last on beat 1 with CdBeats=2 -> snoop_err_o[0]=1 and stays 1 until rst_i.
REQ-032 rst_i in WAIT_CD -> next cycle busy 0, err 0, line 0, core ac_valid follows CCU.
